gate_test_sequencer: RTL and testbench

Self-checking stimulus controller for the 2-input universal gate cells (NOR, NAND, and related cells). On `start` it drives every input combination onto the gate under test and waits a programmable settle time. It then samples the gate output and compares it against a 4-bit expected truth table. The block replaces free-running toggle stimulus with a clocked, repeatable sequence. It reports pass/fail, an error count and a per-vector failure map.

---
 rtl/gate_test_pkg.sv | 20 ++
 rtl/settle_timer.sv | 36 +++
 rtl/gate_test_sequencer.sv | 113 +++++++++++
 tb/tb_gate_test_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared types and truth-table constants for the gate test sequencer
package gate_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int NUM_VECTORS = 4;

  // Bit i is the gate output for input vector i = {vin2,vin1}
  localparam logic [NUM_VECTORS-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter; expired_o after N enabled cycles, bypassed when N=0
module settle_timer #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (N < 2) ? 1 : $clog2(N + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(N);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiring on the last count lets the FSM leave SETTLE after exactly N cycles
  assign expired_o = (N == 0) || (cnt_q == W'(1));

endmodule

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - sweeps all four inputs of a 2-input gate and checks vout against a truth table
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] truth,
  input  logic       vout,
  output logic       vin1,
  output logic       vin2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_map
);

  localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [1:0] vin_q, vin_d;
  logic [3:0] truth_q, truth_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       settle_expired;

  settle_timer #(.N(SETTLE_CYCLES)) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == ST_APPLY),
    .en_i      (state_q == ST_SETTLE),
    .expired_o (settle_expired)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    vin_d   = vin_q;
    truth_d = truth_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          truth_d = truth;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        vin_d   = vec_q;
        state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_expired) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (vout != truth_q[vec_q]) begin
          fail_d[vec_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end
        // pass is resolved here so it is already valid during the done pulse
        if (vec_q == LAST_VEC) begin
          pass_d  = (err_d == 3'd0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      vin_q   <= '0;
      truth_q <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      vin_q   <= vin_d;
      truth_q <= truth_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign vin1      = vin_q[0];
  assign vin2      = vin_q[1];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_map  = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - table-driven and scoreboard bench for gate_test_sequencer
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  localparam int MODE_NOR    = 0;
  localparam int MODE_STUCK0 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, vout, vin1, vin2, busy, done, pass;
  logic [3:0] truth, fail_map;
  logic [2:0] err_count;
  int         mode;

  logic       start_z, vout_z, vin1_z, vin2_z, busy_z, done_z, pass_z;
  logic [3:0] truth_z, fail_map_z;
  logic [2:0] err_count_z;

  assign vout   = (mode == MODE_NOR) ? ~(vin1 | vin2) : 1'b0;
  assign vout_z = ~(vin1_z | vin2_z);

  gate_test_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .truth(truth), .vout(vout),
    .vin1(vin1), .vin2(vin2), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_map(fail_map)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .truth(truth_z), .vout(vout_z),
    .vin1(vin1_z), .vin2(vin2_z), .busy(busy_z), .done(done_z), .pass(pass_z),
    .err_count(err_count_z), .fail_map(fail_map_z)
  );

  typedef struct {
    logic [3:0] fmap;
    logic [2:0] err;
    logic       pas;
  } exp_t;

  typedef struct {
    int         md;
    logic [3:0] tt;
    logic [3:0] fmap;
    logic [2:0] err;
    logic       pas;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input int md, input logic [3:0] tt);
    exp_t r;
    logic g;
    r.fmap = '0;
    r.err  = '0;
    for (int i = 0; i < 4; i++) begin
      g = (md == MODE_NOR) ? ~(i[0] | i[1]) : 1'b0;
      if (g != tt[i]) begin
        r.fmap[i] = 1'b1;
        r.err     = r.err + 3'd1;
      end
    end
    r.pas = (r.err == 3'd0);
    return r;
  endfunction

  // One sweep on the default-settle DUT; inject pulses start during SETTLE of vector 1 and in DONE
  task automatic sweep(input int md, input logic [3:0] tt, input exp_t e, input bit inject);
    int   lat;
    int   ndone;
    exp_t got;
    lat   = -1;
    ndone = 0;
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    truth = tt;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    truth = ~tt;
    chk("busy_after_start", busy, 1);
    for (int m = 1; m <= 24; m++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if ((m % 4) == 1 && m < 16) chk("vin_order", {vin2, vin1}, (m - 1) / 4);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = m;
          chk("sb_depth", sb_q.size(), 1);
          if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            chk("fail_map", fail_map, got.fmap);
            chk("err_count", err_count, got.err);
            chk("pass", pass, got.pas);
          end
        end
      end
      if (inject && (m == 6 || done)) start = 1'b1;
    end
    chk("done_latency", lat, 16);
    chk("done_count", ndone, 1);
    chk("idle_after_sweep", busy, 0);
    chk("pass_held", pass, e.pas);
    chk("vin_hold_11", {vin2, vin1}, 3);
  endtask

  initial begin
    int nd;
    int lat;
    start   = 1'b0;
    truth   = '0;
    mode    = MODE_NOR;
    start_z = 1'b0;
    truth_z = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vin", {vin2, vin1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fmap", fail_map, 0);
    chk("rst_busy_z", busy_z, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{MODE_NOR,    TT_NOR,  4'b0000, 3'd0, 1'b1};
    tbl[1] = '{MODE_NOR,    TT_NAND, 4'b0110, 3'd2, 1'b0};
    tbl[2] = '{MODE_STUCK0, TT_NOR,  4'b0001, 3'd1, 1'b0};
    tbl[3] = '{MODE_NOR,    TT_NOR,  4'b0000, 3'd0, 1'b1};
    tbl[4] = '{MODE_NOR,    TT_AND,  4'b1001, 3'd2, 1'b0};
    tbl[5] = '{MODE_NOR,    TT_OR,   4'b1111, 3'd4, 1'b0};
    for (int i = 0; i < 6; i++) begin
      sweep(tbl[i].md, tbl[i].tt, '{fmap: tbl[i].fmap, err: tbl[i].err, pas: tbl[i].pas}, 1'b0);
    end

    sweep(MODE_NOR, TT_NAND, model(MODE_NOR, TT_NAND), 1'b1);

    // Reset in the middle of vector 2
    @(negedge clk);
    mode  = MODE_NOR;
    start = 1'b1;
    truth = TT_NOR;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("vin_before_reset", {vin2, vin1}, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_vin", {vin2, vin1}, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_pass", pass, 0);
    chk("async_rst_err", err_count, 0);
    chk("async_rst_fmap", fail_map, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int m = 0; m < 20; m++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no_done_after_reset", nd, 0);
    chk("idle_after_reset", busy, 0);
    sweep(MODE_NOR, TT_NOR, model(MODE_NOR, TT_NOR), 1'b0);

    // Zero settle cycles
    @(negedge clk);
    start_z = 1'b1;
    truth_z = TT_NOR;
    @(posedge clk); #1;
    start_z = 1'b0;
    chk("z_busy_after_start", busy_z, 1);
    lat = -1;
    for (int m = 1; m <= 16; m++) begin
      @(posedge clk); #1;
      if (done_z && lat < 0) begin
        lat = m;
        chk("z_pass", pass_z, 1);
        chk("z_err", err_count_z, 0);
        chk("z_fmap", fail_map_z, 0);
      end
    end
    chk("z_done_latency", lat, 8);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
